npc_core_sequencer: RTL and testbench

Multi-cycle sequencer for the NPC core. Fetches each instruction from instruction memory over a valid/ready handshake, latches it for `control_unit`, holds it stable for one execute cycle, gates the register-file write and computes the next PC (sequential, JAL, JALR). Halts on `ebreak` or on a fetch timeout. It sits between the instruction memory port and the decode/ALU/register-file datapath.

---
 rtl/npc_pkg.sv | 16 +
 rtl/npc_pc_next.sv | 27 ++
 rtl/npc_core_sequencer.sv | 127 ++++++++++++
 tb/tb_npc_core_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core sequencer and its next-PC helper.
package npc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH_REQ  = 3'd1,
      ST_FETCH_WAIT = 3'd2,
      ST_EXEC       = 3'd3,
      ST_HALT       = 3'd4
   } seq_state_t;

   localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/npc_pc_next.sv
// Combinational next-PC select: JAL target, JALR target with LSB cleared, or pc+4.
module npc_pc_next
   import npc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        is_jal,
   input  logic        is_jalr,
   output logic [31:0] next_pc
);

   logic [31:0] jalr_sum;

   assign jalr_sum = rs1_data + imm;

   // JAL has priority when the decoder raises both flags.
   always_comb begin
      next_pc = pc + 32'd4;
      if (is_jal) begin
         next_pc = pc + imm;
      end else if (is_jalr) begin
         next_pc = jalr_sum & ~32'h1;
      end
   end

endmodule

// File: rtl/npc_core_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetch handshake, instruction latch, write gating and PC update.
module npc_core_sequencer
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
   parameter int          FETCH_TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] inst,
   input  logic        reg_write,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        rf_wen,
   output logic        retire,
   output logic [63:0] instret,
   output logic        halted,
   output logic        fetch_err
);

   localparam logic [7:0] TMO_LIMIT = 8'(FETCH_TIMEOUT);

   seq_state_t  state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] inst_reg, inst_next;
   logic [63:0] instret_reg, instret_next;
   logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
   logic        fetch_err_reg, fetch_err_next;
   logic [31:0] pc_target;
   logic        exec_live;

   // An ebreak sitting in EXEC neither writes nor retires.
   assign exec_live = (state_reg == ST_EXEC) && (inst_reg != INST_EBREAK);

   npc_pc_next u_pc_next (
      .pc       (pc_reg),
      .imm      (imm),
      .rs1_data (rs1_data),
      .is_jal   (is_jal),
      .is_jalr  (is_jalr),
      .next_pc  (pc_target)
   );

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      inst_next      = inst_reg;
      instret_next   = instret_reg;
      tmo_cnt_next   = tmo_cnt_reg;
      fetch_err_next = fetch_err_reg;
      case (state_reg)
         ST_IDLE: begin
            state_next = ST_FETCH_REQ;
         end
         ST_FETCH_REQ: begin
            if (imem_req_ready) begin
               state_next   = ST_FETCH_WAIT;
               tmo_cnt_next = 8'd0;
            end
         end
         ST_FETCH_WAIT: begin
            if (imem_rsp_valid) begin
               inst_next  = imem_rsp_data;
               state_next = ST_EXEC;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 8'd1;
               if (tmo_cnt_next == TMO_LIMIT) begin
                  state_next     = ST_HALT;
                  fetch_err_next = 1'b1;
               end
            end
         end
         ST_EXEC: begin
            if (inst_reg == INST_EBREAK) begin
               state_next = ST_HALT;
            end else begin
               pc_next      = pc_target;
               instret_next = instret_reg + 64'd1;
               state_next   = ST_FETCH_REQ;
            end
         end
         default: begin
            state_next = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         pc_reg        <= RESET_PC;
         inst_reg      <= INST_NOP;
         instret_reg   <= 64'd0;
         tmo_cnt_reg   <= 8'd0;
         fetch_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         inst_reg      <= inst_next;
         instret_reg   <= instret_next;
         tmo_cnt_reg   <= tmo_cnt_next;
         fetch_err_reg <= fetch_err_next;
      end
   end

   assign imem_req_valid = (state_reg == ST_FETCH_REQ);
   assign imem_addr      = pc_reg;
   assign inst           = inst_reg;
   assign pc             = pc_reg;
   assign pc_plus4       = pc_reg + 32'd4;
   assign rf_wen         = exec_live && reg_write;
   assign retire         = exec_live;
   assign instret        = instret_reg;
   assign halted         = (state_reg == ST_HALT);
   assign fetch_err      = fetch_err_reg;

endmodule

// File: tb/tb_npc_core_sequencer.sv
// Directed bench for npc_core_sequencer: bench-driven memory handshake and decoder inputs.
module tb_npc_core_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] inst;
   logic        reg_write;
   logic        is_jal;
   logic        is_jalr;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        rf_wen;
   logic        retire;
   logic [63:0] instret;
   logic        halted;
   logic        fetch_err;

   int n_tests = 0;
   int n_fail  = 0;

   npc_core_sequencer #(
      .RESET_PC      (32'h8000_0000),
      .FETCH_TIMEOUT (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst           (inst),
      .reg_write      (reg_write),
      .is_jal         (is_jal),
      .is_jalr        (is_jalr),
      .imm            (imm),
      .rs1_data       (rs1_data),
      .pc             (pc),
      .pc_plus4       (pc_plus4),
      .rf_wen         (rf_wen),
      .retire         (retire),
      .instret        (instret),
      .halted         (halted),
      .fetch_err      (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s = %h", tag, act);
      end
   endtask

   // Holds rst for one rising edge, checks the reset image, and leaves the DUT in FETCH_REQ.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_pc", 64'(pc), 64'h8000_0000);
      check("rst_inst", 64'(inst), 64'h0000_0013);
      check("rst_instret", instret, 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_fetch_err", 64'(fetch_err), 64'd0);
      check("rst_retire", 64'(retire), 64'd0);
      check("rst_rf_wen", 64'(rf_wen), 64'd0);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Runs the fetch handshake with optional stalls; returns at the EXEC-cycle negedge.
   task automatic fetch(input logic [31:0] word, input int rdy_wait, input int rsp_wait,
                        input logic [31:0] exp_addr);
      check("req_valid", 64'(imem_req_valid), 64'd1);
      check("req_addr", 64'(imem_addr), 64'(exp_addr));
      for (int i = 0; i < rdy_wait; i++) begin
         imem_req_ready = 1'b0;
         @(negedge clk);
         check("stall_valid", 64'(imem_req_valid), 64'd1);
         check("stall_addr", 64'(imem_addr), 64'(exp_addr));
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      check("wait_valid", 64'(imem_req_valid), 64'd0);
      for (int i = 0; i < rsp_wait; i++) begin
         @(negedge clk);
         check("wait_retire", 64'(retire), 64'd0);
         check("wait_addr", 64'(imem_addr), 64'(exp_addr));
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      check("exec_inst", 64'(inst), 64'(word));
   endtask

   // Drives decoder inputs during EXEC, checks EXEC outputs and the following fetch address.
   task automatic exec(input logic rw, input logic jal, input logic jalr,
                       input logic [31:0] imm_v, input logic [31:0] rs1_v,
                       input logic [31:0] exp_link, input logic [31:0] exp_next,
                       input logic [63:0] exp_instret);
      reg_write = rw;
      is_jal    = jal;
      is_jalr   = jalr;
      imm       = imm_v;
      rs1_data  = rs1_v;
      #1;
      check("exec_rf_wen", 64'(rf_wen), 64'(rw));
      check("exec_retire", 64'(retire), 64'd1);
      check("exec_pc_plus4", 64'(pc_plus4), 64'(exp_link));
      @(negedge clk);
      reg_write = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      imm       = 32'h0;
      rs1_data  = 32'h0;
      check("next_retire", 64'(retire), 64'd0);
      check("next_pc", 64'(pc), 64'(exp_next));
      check("next_instret", instret, exp_instret);
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      reg_write      = 1'b0;
      is_jal         = 1'b0;
      is_jalr        = 1'b0;
      imm            = 32'h0;
      rs1_data       = 32'h0;
      @(negedge clk);
      do_reset();

      // addi x1,x0,5 then nop, zero-wait memory
      fetch(32'h0050_0093, 0, 0, 32'h8000_0000);
      exec(1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 32'h8000_0004, 32'h8000_0004, 64'd1);
      fetch(32'h0000_0013, 0, 0, 32'h8000_0004);
      exec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8000_0008, 32'h8000_0008, 64'd2);

      // JAL +0x10 from 0x8000_0008
      fetch(32'h0100_00EF, 0, 0, 32'h8000_0008);
      exec(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h8000_000C, 32'h8000_0018, 64'd3);

      // JALR clears the target LSB
      fetch(32'h0020_80E7, 0, 0, 32'h8000_0018);
      exec(1'b1, 1'b0, 1'b1, 32'h2, 32'h8000_0101, 32'h8000_001C, 32'h8000_0102, 64'd4);

      // Both flags set: JAL wins, target pc+imm rather than rs1+imm
      fetch(32'h0040_00EF, 0, 0, 32'h8000_0102);
      exec(1'b0, 1'b1, 1'b1, 32'h4, 32'h1234_0000, 32'h8000_0106, 32'h8000_0106, 64'd5);

      // Ready held low 4 cycles, response delayed 3 cycles
      fetch(32'h0000_0013, 4, 3, 32'h8000_0106);
      exec(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8000_010A, 32'h8000_010A, 64'd6);

      // Response withheld: timeout after 8 FETCH_WAIT cycles
      check("tmo_req_valid", 64'(imem_req_valid), 64'd1);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      for (int i = 0; i < 7; i++) @(negedge clk);
      check("tmo_not_yet_halted", 64'(halted), 64'd0);
      @(negedge clk);
      check("tmo_halted", 64'(halted), 64'd1);
      check("tmo_fetch_err", 64'(fetch_err), 64'd1);
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0050_0093;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("halt_req_valid", 64'(imem_req_valid), 64'd0);
         check("halt_retire", 64'(retire), 64'd0);
      end
      check("halt_instret", instret, 64'd6);
      check("halt_still", 64'(halted), 64'd1);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;

      // ebreak halts without write or retire; reset recovers
      do_reset();
      fetch(32'h0010_0073, 0, 0, 32'h8000_0000);
      reg_write = 1'b1;
      #1;
      check("ebreak_rf_wen", 64'(rf_wen), 64'd0);
      check("ebreak_retire", 64'(retire), 64'd0);
      @(negedge clk);
      reg_write = 1'b0;
      check("ebreak_halted", 64'(halted), 64'd1);
      check("ebreak_fetch_err", 64'(fetch_err), 64'd0);
      check("ebreak_pc", 64'(pc), 64'h8000_0000);
      check("ebreak_instret", instret, 64'd0);
      check("ebreak_req_valid", 64'(imem_req_valid), 64'd0);
      do_reset();
      check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
      check("post_rst_addr", 64'(imem_addr), 64'h8000_0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
